period_meter: RTL and testbench



---
 rtl/period_meter.sv | 155 +++++++++++++++
 tb/tb_period_meter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// rtl/period_meter.sv - period and high-time meter for a slow square-wave input
//
// Purpose:
//   Measures the period and high time of sig_in in clk cycles. sig_in is
//   synchronized by a three-flop chain. Rising and falling edges are detected
//   on the synchronized signal. A no-signal timeout fires when no rising edge
//   has been seen for TIMEOUT cycles.
//
// Parameters:
//   WIDTH        width of period, high_time and the internal counter
//   TIMEOUT      cycles without a rising edge before no_signal is raised
//                (2 <= TIMEOUT <= 2^WIDTH-1)
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   sig_in       asynchronous square-wave or button input
//   period       clk cycles between the last two synchronized rising edges
//   high_time    clk cycles from a rising edge to the following falling edge
//   period_valid one-cycle pulse when period/high_time update
//   no_signal    high while no valid measurement is current

module period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             no_signal
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] hi_latch_q, hi_latch_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             period_valid_q, period_valid_d;
    logic             no_signal_q, no_signal_d;

    logic rise;
    logic fall;
    logic timeout_hit;

    // s1 is the metastability catcher; edges are taken between s2 and s3 so
    // both edge strobes come from settled flops and cannot coincide.
    assign rise        = s2_q & ~s3_q;
    assign fall        = ~s2_q & s3_q;
    assign timeout_hit = (counter_q == TIMEOUT_C);

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            counter_q      <= '0;
            hi_latch_q     <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            no_signal_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            s1_q           <= sig_in;
            s2_q           <= s1_q;
            s3_q           <= s2_q;
            counter_q      <= counter_d;
            hi_latch_q     <= hi_latch_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            no_signal_q    <= no_signal_d;
        end
    end

    // Next-state logic; a rise outranks the timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise && timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        counter_d      = counter_q;
        hi_latch_d     = hi_latch_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        period_valid_d = 1'b0;
        no_signal_d    = no_signal_q;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (rise) begin
                    // First rise only starts counting; the stale high time
                    // from an earlier run must not leak into the new one.
                    counter_d  = ONE_C;
                    hi_latch_d = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d       = counter_q;
                    high_time_d    = hi_latch_q;
                    period_valid_d = 1'b1;
                    no_signal_d    = 1'b0;
                    counter_d      = ONE_C;
                end else if (timeout_hit) begin
                    // Results hold their last values; only the flag drops.
                    no_signal_d = 1'b1;
                    counter_d   = '0;
                end else begin
                    counter_d = counter_q + ONE_C;
                end
                if (fall) begin
                    hi_latch_d = counter_q;
                end
            end
            default: begin
                counter_d = '0;
            end
        endcase
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard testbench for period_meter

module tb_period_meter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             no_signal;

    period_meter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .no_signal    (no_signal)
    );

    typedef struct {
        int cyc;
        int p;
        int h;
        bit first;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_rise_cyc = 0;
    bit   prev_valid = 0;
    bit   prev_ns    = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every period_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (period_valid) begin
                if (q.size() == 0) begin
                    check("spurious_period_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("period", int'(period), e.p);
                    check("high_time", int'(high_time), e.h);
                    check("no_signal_on_valid", int'(no_signal), 0);
                    if (e.first) check("no_signal_before_first", int'(prev_ns), 1);
                end
                check("valid_not_back_to_back", int'(prev_valid), 0);
            end
        end
        prev_valid = period_valid;
        prev_ns    = no_signal;
    end

    // One high phase of h cycles followed by l low cycles, driven on negedges.
    task automatic pulse(input int h, input int l, input bit v, input int p,
                         input int hx, input bit first);
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            sig_in = 1'b1;
            if (i == 0) begin
                last_rise_cyc = cyc;
                if (v) q.push_back('{cyc: cyc + 3, p: p, h: hx, first: first});
            end
        end
        for (int i = 0; i < l; i++) begin
            @(negedge clk);
            sig_in = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sig_in = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_period", int'(period), 0);
        check("reset_high_time", int'(high_time), 0);
        check("reset_period_valid", int'(period_valid), 0);
        check("reset_no_signal", int'(no_signal), 1);
        rst = 1'b0;
        idle(3);

        // divide-by-2 input: first rise only arms, then p=2 h=1 every 2 cycles
        pulse(1, 1, 0, 0, 0, 0);
        pulse(1, 1, 1, 2, 1, 1);
        for (int i = 0; i < 5; i++) pulse(1, 1, 1, 2, 1, 0);
        idle(30);
        check("div2_timed_out", int'(no_signal), 1);

        // 3 high / 7 low
        pulse(3, 7, 0, 0, 0, 0);
        pulse(3, 7, 1, 10, 3, 1);
        pulse(3, 7, 1, 10, 3, 0);
        // hold low: timeout exactly TIMEOUT cycles after the last sync'd rise
        while (cyc < last_rise_cyc + 22) @(negedge clk);
        check("timeout_not_early", int'(no_signal), 0);
        @(negedge clk);
        check("timeout_no_signal", int'(no_signal), 1);
        check("timeout_period_held", int'(period), 10);
        check("timeout_high_held", int'(high_time), 3);
        idle(5);

        // resume with period 20 == TIMEOUT: rise beats timeout
        pulse(3, 17, 0, 0, 0, 0);
        pulse(3, 17, 1, 20, 3, 1);
        pulse(3, 17, 1, 20, 3, 0);
        pulse(3, 7, 1, 20, 3, 0);
        pulse(3, 7, 1, 10, 3, 0);
        check("period20_no_signal_low", int'(no_signal), 0);

        // reset mid-measurement in a period-10 stream
        pulse(3, 2, 1, 10, 3, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_period", int'(period), 0);
        check("midrst_high_time", int'(high_time), 0);
        check("midrst_no_signal", int'(no_signal), 1);
        idle(4);
        pulse(3, 7, 0, 0, 0, 0);
        pulse(3, 7, 1, 10, 3, 1);

        // seamless change from 10/3 to 6/5
        pulse(3, 7, 1, 10, 3, 0);
        pulse(5, 1, 1, 10, 3, 0);
        pulse(5, 1, 1, 6, 5, 0);
        pulse(5, 1, 1, 6, 5, 0);
        idle(30);

        check("all_expected_seen", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
